// File: rtl/stack_cpu_controller.sv
// Multicycle control FSM for the 8-bit stack CPU: decodes op/Zero into per-cycle datapath
// controls. Moore outputs from state; only PCWrite in JZ_TEST looks at Zero.
module stack_cpu_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         op,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               LoadA,
  output logic               LoadB,
  output logic               Push,
  output logic               Pop,
  output logic               Tos,
  output logic               AdrSrc,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_POP_B    = STATE_W'(2),
    S_POP_A    = STATE_W'(3),
    S_EXEC     = STATE_W'(4),
    S_PUSH_RES = STATE_W'(5),
    S_MEM_RD   = STATE_W'(6),
    S_PUSH_MEM = STATE_W'(7),
    S_MEM_WR   = STATE_W'(8),
    S_JMP      = STATE_W'(9),
    S_PEEK     = STATE_W'(10),
    S_JZ_TEST  = STATE_W'(11)
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_op;

  // op is only trusted in DECODE and POP_B; EXEC uses the copy taken there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_op    <= 3'b000;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE || r_state == S_POP_B) r_op <= op;
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    LoadA      = 1'b0;
    LoadB      = 1'b0;
    Push       = 1'b0;
    Pop        = 1'b0;
    Tos        = 1'b0;
    AdrSrc     = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    case (r_state)
      S_FETCH: begin
        // PC - 8'hFF == PC + 1
        IRWrite    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 3'b001;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          3'b011:  w_next = S_POP_A;
          3'b100:  w_next = S_MEM_RD;
          3'b110:  w_next = S_JMP;
          3'b111:  w_next = S_PEEK;
          default: w_next = S_POP_B;
        endcase
      end
      S_POP_B: begin
        Pop   = 1'b1;
        LoadB = 1'b1;
        if (op == 3'b101)     w_next = S_MEM_WR;
        else if (op <= 3'b010) w_next = S_POP_A;
        else                  w_next = S_FETCH;
      end
      S_POP_A: begin
        Pop    = 1'b1;
        LoadA  = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        ALUSrcA    = 2'b10;
        ALUControl = r_op;
        w_next     = S_PUSH_RES;
      end
      S_PUSH_RES: begin
        Push = 1'b1;
      end
      S_MEM_RD: begin
        ResultSrc = 2'b11;
        AdrSrc    = 1'b1;
        w_next    = S_PUSH_MEM;
      end
      S_PUSH_MEM: begin
        ResultSrc = 2'b01;
        Push      = 1'b1;
      end
      S_MEM_WR: begin
        ResultSrc = 2'b11;
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
      end
      S_JMP: begin
        ResultSrc = 2'b11;
        PCWrite   = 1'b1;
      end
      S_PEEK: begin
        Tos    = 1'b1;
        LoadA  = 1'b1;
        w_next = S_JZ_TEST;
      end
      S_JZ_TEST: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b10;
        ALUControl = 3'b010;
        ResultSrc  = 2'b11;
        PCWrite    = Zero;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset cycle must never disturb stack, PC or memory.
    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      LoadA      = 1'b0;
      LoadB      = 1'b0;
      Push       = 1'b0;
      Pop        = 1'b0;
      Tos        = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Cycle-by-cycle check of stack_cpu_controller state and control outputs against
// a table of per-instruction state paths and per-state control words.
module tb_stack_cpu_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic        Zero;
  logic        PCWrite, IRWrite, MemWrite, LoadA, LoadB, Push, Pop, Tos, AdrSrc, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUControl;
  logic [3:0]  state;
  logic [18:0] w_ctl;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_POP_B = 4'd2, ST_POP_A = 4'd3,
                         ST_EXEC = 4'd4, ST_PUSH_RES = 4'd5, ST_MEM_RD = 4'd6,
                         ST_PUSH_MEM = 4'd7, ST_MEM_WR = 4'd8, ST_JMP = 4'd9,
                         ST_PEEK = 4'd10, ST_JZ_TEST = 4'd11;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic        zero;
    logic [3:0]  st;
    logic [18:0] ctl;
  } vec_t;

  vec_t        tbl[$];
  logic [22:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  stack_cpu_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .LoadA(LoadA),
    .LoadB(LoadB), .Push(Push), .Pop(Pop), .Tos(Tos), .AdrSrc(AdrSrc),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  // {PCWrite,IRWrite,MemWrite,LoadA,LoadB,Push,Pop,Tos,AdrSrc,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}
  assign w_ctl = {PCWrite, IRWrite, MemWrite, LoadA, LoadB, Push, Pop, Tos, AdrSrc, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

  function automatic logic [18:0] exp_ctl(input logic [3:0] st, input logic [2:0] o,
                                          input logic z);
    case (st)
      ST_FETCH:    return 19'b1100000000_10_00_10_001;
      ST_POP_B:    return 19'b0000101000_00_00_00_000;
      ST_POP_A:    return 19'b0001001000_00_00_00_000;
      ST_EXEC:     return {10'b0000000000, 2'b00, 2'b10, 2'b00, o};
      ST_PUSH_RES: return 19'b0000010000_00_00_00_000;
      ST_MEM_RD:   return 19'b0000000010_11_00_00_000;
      ST_PUSH_MEM: return 19'b0000010000_01_00_00_000;
      ST_MEM_WR:   return 19'b0010000010_11_00_00_000;
      ST_JMP:      return 19'b1000000000_11_00_00_000;
      ST_PEEK:     return 19'b0001000100_00_00_00_000;
      ST_JZ_TEST:  return {z, 9'b000000000, 2'b11, 2'b10, 2'b10, 3'b010};
      default:     return 19'd0;
    endcase
  endfunction

  // Appends the state path of one instruction; stop>0 truncates it to that many cycles.
  task automatic add_instr(input logic [2:0] o, input logic z, input int stop);
    int         path[$];
    logic [3:0] st;
    logic [2:0] d_op;
    logic       d_z;
    case (o)
      3'd0, 3'd1, 3'd2: path = '{0, 1, 2, 3, 4, 5};
      3'd3:             path = '{0, 1, 3, 4, 5};
      3'd4:             path = '{0, 1, 6, 7};
      3'd5:             path = '{0, 1, 2, 8};
      3'd6:             path = '{0, 1, 9};
      default:          path = '{0, 1, 10, 11};
    endcase
    for (int k = 0; k < path.size(); k++) begin
      if (stop > 0 && k >= stop) break;
      st   = 4'(path[k]);
      d_op = (st == ST_DECODE || st == ST_POP_B || st == ST_EXEC) ? o : 3'($urandom_range(0, 7));
      d_z  = (st == ST_JZ_TEST) ? z : 1'($urandom_range(0, 1));
      tbl.push_back('{1'b0, d_op, d_z, st, exp_ctl(st, o, d_z)});
    end
  endtask

  task automatic add_rst(input logic [3:0] st);
    tbl.push_back('{1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), st, 19'd0});
  endtask

  initial begin
    logic [22:0] got;
    logic [22:0] e;
    rst  = 1'b1;
    op   = 3'($urandom_range(0, 7));
    Zero = 1'($urandom_range(0, 1));

    // Two reset edges from an unknown state; check after the first.
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== ST_FETCH) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", state, ST_FETCH);
    end
    checks++;
    if (w_ctl !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", w_ctl, 19'd0);
    end

    for (int o = 0; o < 7; o++) add_instr(3'(o), 1'b0, 0);
    add_instr(3'd7, 1'b1, 0);
    add_instr(3'd7, 1'b0, 0);
    // SUB abandoned in EXEC: no Push, FETCH after release.
    add_instr(3'd1, 1'b0, 4);
    add_rst(ST_EXEC);
    add_instr(3'd4, 1'b0, 0);
    // Two-cycle reset part way through PUSH.
    add_instr(3'd4, 1'b0, 2);
    add_rst(ST_MEM_RD);
    add_rst(ST_FETCH);
    add_instr(3'd5, 1'b0, 0);
    for (int n = 0; n < 10; n++)
      add_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst  = tbl[i].rst;
      op   = tbl[i].op;
      Zero = tbl[i].zero;
      exp_q.push_back({tbl[i].st, tbl[i].ctl});
      @(negedge clk);
      got = {state, w_ctl};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL row_%0d scoreboard empty got %h", i, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL row_%0d state/ctl got %h_%h exp %h_%h", i, got[22:19], got[18:0],
                   e[22:19], e[18:0]);
        end
      end
      checks++;
      if ((Push && Pop) || (MemWrite && IRWrite) || RegWrite) begin
        errors++;
        $display("FAIL row_%0d exclusive got Push=%b Pop=%b MemWrite=%b IRWrite=%b RegWrite=%b exp no conflict",
                 i, Push, Pop, MemWrite, IRWrite, RegWrite);
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
